// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared definitions for the radix-4 Booth partial-product generator:
//   - WIDTH_DEF : default operand width
//   - digit_e   : Booth digit encoding, bit 2 is the sign of the digit
//   - recode()  : multiplier bit triplet {b[2i+1], b[2i], b[2i-1]} -> digit
package booth_pkg;

    localparam int WIDTH_DEF = 12;

    // Bit 2 is the digit sign, bits 1:0 the magnitude (0, 1 or 2).
    typedef enum logic [2:0] {
        ZERO = 3'b000,
        POS1 = 3'b001,
        POS2 = 3'b010,
        NEG1 = 3'b101,
        NEG2 = 3'b110
    } digit_e;

    function automatic digit_e recode(input logic [2:0] trip);
        digit_e d;
        case (trip)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;  // 000 and 111 both encode zero
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder
//   Combinational generation of one radix-4 Booth partial product.
//   Ports:
//     dig_i : Booth digit for this row
//     a_i   : multiplicand, two's complement, WIDTH bits
//     pp_o  : partial product, WIDTH+1 bits (one's complement when negative)
//     neg_o : +1 correction completing the two's complement negation
module booth_recoder
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  digit_e             dig_i,
    input  logic [WIDTH-1:0]   a_i,
    output logic [WIDTH:0]     pp_o,
    output logic               neg_o
);

    logic [WIDTH:0] mag;

    always_comb begin
        mag = '0;
        case (dig_i)
            POS1, NEG1: mag = {a_i[WIDTH-1], a_i};
            POS2, NEG2: mag = {a_i, 1'b0};
            default:    mag = '0;
        endcase
        // Negation is split into bitwise invert here plus the +1 on neg_o,
        // which the reduction array absorbs as an extra bit in the column.
        neg_o = (dig_i == NEG1) || (dig_i == NEG2);
        pp_o  = neg_o ? ~mag : mag;
    end

endmodule

// File: rtl/booth_pp_gen.sv
// booth_pp_gen
//   Two-stage registered radix-4 Booth recoder / partial-product generator.
//   Stage 1 captures the multiplicand and the recoded Booth digits; stage 2
//   captures the partial products and negate-correction bits.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid / in_ready   : operand handshake
//     in_a, in_b            : multiplicand / multiplier, two's complement
//     out_valid / out_ready : result handshake
//     out_pp                : NPP packed partial products, pp_i at [i*(WIDTH+1) +: WIDTH+1]
//     out_neg               : per-row +1 correction at weight 4^i
//   WIDTH must be even and at least 4.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int NPP   = WIDTH / 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NPP*(WIDTH+1)-1:0] out_pp,
    output logic [NPP-1:0]           out_neg
);

    localparam int PPW = WIDTH + 1;

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [3*NPP-1:0]     dig_q, dig_d, dig_comb;
    logic                 s2_valid_q, s2_valid_d;
    logic [NPP*PPW-1:0]   pp_q, pp_d, pp_comb;
    logic [NPP-1:0]       neg_q, neg_d, neg_comb;
    logic                 s1_load, s2_load;
    logic [WIDTH:0]       b_ext;

    // Appending b[-1]=0 makes triplet i simply b_ext[2i +: 3].
    assign b_ext = {in_b, 1'b0};

    always_comb begin
        dig_comb = '0;
        for (int i = 0; i < NPP; i++) begin
            dig_comb[3*i +: 3] = recode(b_ext[2*i +: 3]);
        end
    end

    for (genvar g = 0; g < NPP; g++) begin : g_row
        booth_recoder #(.WIDTH(WIDTH)) u_rec (
            .dig_i (digit_e'(dig_q[3*g +: 3])),
            .a_i   (a_q),
            .pp_o  (pp_comb[g*PPW +: PPW]),
            .neg_o (neg_comb[g])
        );
    end

    // Stage 2 is free when empty or draining this cycle; stage 1 is free
    // when empty or moving into stage 2.
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        dig_d      = dig_q;
        s2_valid_d = s2_valid_q;
        pp_d       = pp_q;
        neg_d      = neg_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            a_d        = in_a;
            dig_d      = dig_comb;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            pp_d       = pp_comb;
            neg_d      = neg_comb;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // ---- stage 1: multiplicand and Booth digits ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            dig_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            dig_q      <= dig_d;
        end
    end

    // ---- stage 2: partial products and negate corrections ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            pp_q       <= '0;
            neg_q      <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            pp_q       <= pp_d;
            neg_q      <= neg_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_pp    = pp_q;
    assign out_neg   = neg_q;

endmodule

// File: tb/tb_booth_pp_gen.sv
module tb_booth_pp_gen;

    localparam int W   = 12;
    localparam int NPP = W / 2;
    localparam int PPW = W + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_a;
    logic [W-1:0]         in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [NPP*PPW-1:0]   out_pp;
    logic [NPP-1:0]       out_neg;

    int n_assert = 0;
    int n_fail   = 0;

    logic [NPP*PPW-1:0] exp_pp;
    longint             sb[$];
    longint             exp_prod;

    always #5 clk = ~clk;

    booth_pp_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pp    (out_pp),
        .out_neg   (out_neg)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Weighted sum of the partial products: sum (sext(pp_i) + neg_i) * 4^i
    function automatic longint psum(input logic [NPP*PPW-1:0] pp, input logic [NPP-1:0] neg);
        longint s = 0;
        for (int i = 0; i < NPP; i++) begin
            logic signed [PPW-1:0] p;
            p = pp[i*PPW +: PPW];
            s += (longint'(p) + longint'(neg[i])) <<< (2 * i);
        end
        return s;
    endfunction

    function automatic longint prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb2;
        sa  = a;
        sb2 = b;
        return longint'(sa) * longint'(sb2);
    endfunction

    // Present one pair, let it be accepted, then wait for it to reach stage 2.
    task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_not_early", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_valid", out_valid, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pp",    out_pp,    '0);
        chk("rst_out_neg",   out_neg,   '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // 1 x 1
        run_vec(12'h001, 12'h001);
        exp_pp = '0;
        exp_pp[0 +: PPW] = 13'h0001;
        chk("v1_pp",  out_pp,  exp_pp);
        chk("v1_neg", out_neg, 6'b000000);

        // 2047 x -2048: single -2 digit in the top row
        run_vec(12'h7FF, 12'h800);
        exp_pp = '0;
        exp_pp[5*PPW +: PPW] = 13'h1001;
        chk("v2_pp",  out_pp,  exp_pp);
        chk("v2_neg", out_neg, 6'b100000);
        chk_s("v2_sum", psum(out_pp, out_neg), -64'sd4192256);

        // -1 x 3
        run_vec(12'hFFF, 12'h003);
        exp_pp = '0;
        exp_pp[1*PPW +: PPW] = 13'h1FFF;
        chk("v3_pp",  out_pp,  exp_pp);
        chk("v3_neg", out_neg, 6'b000001);
        chk_s("v3_sum", psum(out_pp, out_neg), -64'sd3);

        // Drain
        @(posedge clk); #1;
        chk("drain_idle", out_valid, 1'b0);

        // Backpressure: 3 back-to-back pairs, downstream stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 12'h005; in_b = 12'h003;              // 5 * 3 = 15
        #1;
        chk("bp_rdy0", in_ready, 1'b1);
        @(posedge clk); #1;
        in_a = 12'hFF9; in_b = 12'h00B;              // -7 * 11 = -77
        #1;
        chk("bp_rdy1", in_ready, 1'b1);
        @(posedge clk); #1;
        in_a = 12'h064; in_b = 12'hFCE;              // 100 * -50 = -5000
        exp_pp = '0;
        exp_pp[0 +: PPW]   = 13'h1FFA;
        exp_pp[PPW +: PPW] = 13'h0005;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rdy_low",  in_ready,  1'b0);
            chk("bp_valid",    out_valid, 1'b1);
            chk("bp_pp_hold",  out_pp,    exp_pp);
            chk("bp_neg_hold", out_neg,   6'b000001);
            @(posedge clk); #1;
        end
        chk_s("bp_sum0", psum(out_pp, out_neg), 64'sd15);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_valid1", out_valid, 1'b1);
        chk_s("bp_sum1", psum(out_pp, out_neg), -64'sd77);
        @(posedge clk); #1;
        chk("bp_valid2", out_valid, 1'b1);
        chk_s("bp_sum2", psum(out_pp, out_neg), -64'sd5000);
        @(posedge clk); #1;
        chk("bp_empty", out_valid, 1'b0);

        // Reset with two pairs in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 12'h123; in_b = 12'h456;
        @(posedge clk); #1;
        in_a = 12'h9AB; in_b = 12'h7CD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mr_full", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_pp",    out_pp,    '0);
        chk("mr_neg",   out_neg,   '0);
        chk("mr_rdy",   in_ready,  1'b1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("mr_no_stale", out_valid, 1'b0);
        end

        // Random traffic against the sum invariant
        for (int c = 0; c < 2000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            #1;
            if (out_valid && out_ready) begin
                chk("rand_have_exp", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_prod = sb.pop_front();
                    chk_s("rand_sum", psum(out_pp, out_neg), exp_prod);
                end
            end
            if (in_valid && in_ready) sb.push_back(prod(in_a, in_b));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                chk("drain_have_exp", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_prod = sb.pop_front();
                    chk_s("drain_sum", psum(out_pp, out_neg), exp_prod);
                end
            end
            @(posedge clk); #1;
        end
        chk("rand_all_out", sb.size(), 0);
        chk("rand_final_idle", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
